// File: rtl/hazard_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_seq_ctrl
//  Description : Pipeline sequencing controller for the 6-stage core.
//                Generates load-use stalls, taken-branch flushes and the
//                per-register micro-op stream for LM/SM instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_seq_ctrl #(
   parameter logic [3:0] OPC_LM = 4'b0110,
   parameter logic [3:0] OPC_SM = 4'b0111,
   parameter logic [2:0] PC_REG = 3'b111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rr_valid,
   input  logic [3:0] rr_opcode,
   input  logic [2:0] rr_rs1,
   input  logic [2:0] rr_rs2,
   input  logic       rr_use_rs1,
   input  logic       rr_use_rs2,
   input  logic [7:0] rr_mask,
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [2:0] ex_rd,
   input  logic       ex_branch_taken,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id_rr_stall,
   output logic       rr_ex_bubble,
   output logic       flush_if_id,
   output logic       flush_id_rr,
   output logic       seq_valid,
   output logic       seq_is_store,
   output logic [2:0] seq_reg,
   output logic [2:0] seq_offset,
   output logic       seq_last
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } state_t;

   state_t     state_q,    state_d;
   logic [7:0] rem_mask_q, rem_mask_d;
   logic [2:0] offset_q,   offset_d;
   logic       is_store_q, is_store_d;

   logic       w_load_use;
   logic       w_is_lmsm;
   logic [2:0] w_low_idx;
   logic       w_one_left;
   logic       w_store_hazard;
   logic       w_stall;

   // Hazard detection and lowest-set-bit selection for the remaining mask
   always_comb begin
      w_load_use = rr_valid && ex_valid && ex_is_load && (ex_rd != PC_REG) &&
                   ((rr_use_rs1 && (rr_rs1 == ex_rd)) ||
                    (rr_use_rs2 && (rr_rs2 == ex_rd)));
      w_is_lmsm  = (rr_opcode == OPC_LM) || (rr_opcode == OPC_SM);
      // Scan high to low so the last hit wins: that is the lowest set bit
      w_low_idx  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rem_mask_q[i]) begin
            w_low_idx = i[2:0];
         end
      end
      // x & (x-1) is zero exactly when at most one bit is set
      w_one_left = (rem_mask_q != 8'd0) &&
                   ((rem_mask_q & (rem_mask_q - 8'd1)) == 8'd0);
      w_store_hazard = is_store_q && ex_valid && ex_is_load &&
                       (ex_rd == w_low_idx) && (w_low_idx != PC_REG);
   end

   // Next-state and output decode in priority order: reset, flush, hazard, LM/SM
   always_comb begin
      state_d      = state_q;
      rem_mask_d   = rem_mask_q;
      offset_d     = offset_q;
      is_store_d   = is_store_q;
      w_stall      = 1'b0;
      rr_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_rr  = 1'b0;
      seq_valid    = 1'b0;
      seq_is_store = 1'b0;
      seq_reg      = 3'd0;
      seq_offset   = 3'd0;
      seq_last     = 1'b0;

      if (reset) begin
         state_d    = IDLE;
         rem_mask_d = 8'd0;
         offset_d   = 3'd0;
         is_store_d = 1'b0;
      end else if (ex_branch_taken) begin
         // A redirect kills everything younger, including any open sequence
         flush_if_id  = 1'b1;
         flush_id_rr  = 1'b1;
         rr_ex_bubble = 1'b1;
         state_d      = IDLE;
         rem_mask_d   = 8'd0;
         offset_d     = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_load_use) begin
                  // One bubble is enough: next cycle EX holds the NOP
                  w_stall      = 1'b1;
                  rr_ex_bubble = 1'b1;
               end else if (rr_valid && w_is_lmsm && (rr_mask != 8'd0)) begin
                  w_stall      = 1'b1;
                  rr_ex_bubble = 1'b1;
                  rem_mask_d   = rr_mask;
                  offset_d     = 3'd0;
                  is_store_d   = (rr_opcode == OPC_SM);
                  state_d      = SEQ;
               end
            end
            SEQ: begin
               seq_is_store = is_store_q;
               seq_reg      = w_low_idx;
               seq_offset   = offset_q;
               seq_last     = w_one_left;
               if (w_store_hazard) begin
                  // Hold the mask so the same store reissues next cycle
                  w_stall      = 1'b1;
                  rr_ex_bubble = 1'b1;
               end else begin
                  seq_valid  = 1'b1;
                  w_stall    = !w_one_left;
                  rem_mask_d = rem_mask_q & (rem_mask_q - 8'd1);
                  offset_d   = offset_q + 3'd1;
                  if (w_one_left) begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      pc_stall    = w_stall;
      if_id_stall = w_stall;
      id_rr_stall = w_stall;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rem_mask_q <= 8'd0;
         offset_q   <= 3'd0;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_mask_q <= rem_mask_d;
         offset_q   <= offset_d;
         is_store_q <= is_store_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_seq_ctrl
//  Description : Directed self-checking bench for hazard_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       rr_valid;
   logic [3:0] rr_opcode;
   logic [2:0] rr_rs1;
   logic [2:0] rr_rs2;
   logic       rr_use_rs1;
   logic       rr_use_rs2;
   logic [7:0] rr_mask;
   logic       ex_valid;
   logic       ex_is_load;
   logic [2:0] ex_rd;
   logic       ex_branch_taken;
   logic       pc_stall;
   logic       if_id_stall;
   logic       id_rr_stall;
   logic       rr_ex_bubble;
   logic       flush_if_id;
   logic       flush_id_rr;
   logic       seq_valid;
   logic       seq_is_store;
   logic [2:0] seq_reg;
   logic [2:0] seq_offset;
   logic       seq_last;

   int n_assert;
   int n_fail;

   localparam logic [3:0] LM  = 4'b0110;
   localparam logic [3:0] SM  = 4'b0111;
   localparam logic [3:0] ADD = 4'b0000;

   hazard_seq_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .rr_valid        (rr_valid),
      .rr_opcode       (rr_opcode),
      .rr_rs1          (rr_rs1),
      .rr_rs2          (rr_rs2),
      .rr_use_rs1      (rr_use_rs1),
      .rr_use_rs2      (rr_use_rs2),
      .rr_mask         (rr_mask),
      .ex_valid        (ex_valid),
      .ex_is_load      (ex_is_load),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .id_rr_stall     (id_rr_stall),
      .rr_ex_bubble    (rr_ex_bubble),
      .flush_if_id     (flush_if_id),
      .flush_id_rr     (flush_id_rr),
      .seq_valid       (seq_valid),
      .seq_is_store    (seq_is_store),
      .seq_reg         (seq_reg),
      .seq_offset      (seq_offset),
      .seq_last        (seq_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word: {stall x3, bubble, flush x2, valid, store, reg, offset, last}
   function automatic logic [14:0] ev(input logic stall, input logic bub,
                                      input logic fl, input logic sv,
                                      input logic ss, input logic [2:0] rg,
                                      input logic [2:0] off, input logic last);
      return {stall, stall, stall, bub, fl, fl, sv, ss, rg, off, last};
   endfunction

   task automatic chk(input string tag, input logic [14:0] exp);
      logic [14:0] obs;
      @(negedge clk);
      obs = {pc_stall, if_id_stall, id_rr_stall, rr_ex_bubble, flush_if_id,
             flush_id_rr, seq_valid, seq_is_store, seq_reg, seq_offset, seq_last};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      reset = 1'b0; rr_valid = 1'b0; rr_opcode = ADD; rr_rs1 = 3'd0; rr_rs2 = 3'd0;
      rr_use_rs1 = 1'b0; rr_use_rs2 = 1'b0; rr_mask = 8'd0; ex_valid = 1'b0;
      ex_is_load = 1'b0; ex_rd = 3'd0; ex_branch_taken = 1'b0;
   endtask

   task automatic ex_load(input logic [2:0] rd);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
   endtask

   task automatic rr_lmsm(input logic [3:0] opc, input logic [7:0] m);
      rr_valid = 1'b1; rr_opcode = opc; rr_rs1 = 3'd1; rr_use_rs1 = 1'b1; rr_mask = m;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      idle_in();
      @(posedge clk);
      #1;

      // Reset dominates even with a hazard and an LM present
      reset = 1'b1; rr_lmsm(LM, 8'hFF); ex_load(3'd1);
      chk("reset_outputs", ev(0,0,0,0,0,3'd0,3'd0,0));
      idle_in();
      chk("post_reset_idle", ev(0,0,0,0,0,3'd0,3'd0,0));

      // Load-use on rs1, then clears when EX empties
      rr_valid = 1'b1; rr_use_rs1 = 1'b1; rr_rs1 = 3'd3; ex_load(3'd3);
      chk("load_use_rs1", ev(1,1,0,0,0,3'd0,3'd0,0));
      ex_valid = 1'b0;
      chk("load_use_clear", ev(0,0,0,0,0,3'd0,3'd0,0));
      // Load-use on rs2
      idle_in(); rr_valid = 1'b1; rr_use_rs2 = 1'b1; rr_rs2 = 3'd5; ex_load(3'd5);
      chk("load_use_rs2", ev(1,1,0,0,0,3'd0,3'd0,0));
      // PC register is exempt
      idle_in(); rr_valid = 1'b1; rr_use_rs1 = 1'b1; rr_rs1 = 3'd7; ex_load(3'd7);
      chk("pc_exempt", ev(0,0,0,0,0,3'd0,3'd0,0));
      // Matching index but operand not used
      idle_in(); rr_valid = 1'b1; rr_rs1 = 3'd3; ex_load(3'd3);
      chk("no_use", ev(0,0,0,0,0,3'd0,3'd0,0));
      // Matching but EX is not a load
      idle_in(); rr_valid = 1'b1; rr_use_rs1 = 1'b1; rr_rs1 = 3'd3;
      ex_valid = 1'b1; ex_rd = 3'd3;
      chk("not_load", ev(0,0,0,0,0,3'd0,3'd0,0));

      // LM mask 1010_0100: bubble, then R2/R5/R7 at offsets 0/1/2
      idle_in(); rr_lmsm(LM, 8'b1010_0100);
      chk("lm_entry", ev(1,1,0,0,0,3'd0,3'd0,0));
      chk("lm_op0", ev(1,0,0,1,0,3'd2,3'd0,0));
      ex_load(3'd5);   // LM micro-ops never take the store hazard
      chk("lm_op1", ev(1,0,0,1,0,3'd5,3'd1,0));
      ex_valid = 1'b0;
      chk("lm_op2_last", ev(0,0,0,1,0,3'd7,3'd2,1));
      // Back in IDLE: a load-use hazard is recognised again
      idle_in(); rr_valid = 1'b1; rr_use_rs1 = 1'b1; rr_rs1 = 3'd4; ex_load(3'd4);
      chk("lm_back_idle", ev(1,1,0,0,0,3'd0,3'd0,0));

      // SM mask 01 with a load to R0 in EX at T+1
      idle_in(); rr_lmsm(SM, 8'h01);
      chk("sm_entry", ev(1,1,0,0,0,3'd0,3'd0,0));
      ex_load(3'd0);
      chk("sm_store_hazard", ev(1,1,0,0,1,3'd0,3'd0,1));
      ex_valid = 1'b0; ex_is_load = 1'b0;
      chk("sm_reissue", ev(0,0,0,1,1,3'd0,3'd0,1));

      // LM mask FF aborted by a branch at T+2, with a load-use match present
      idle_in(); rr_lmsm(LM, 8'hFF);
      chk("lmff_entry", ev(1,1,0,0,0,3'd0,3'd0,0));
      chk("lmff_op0", ev(1,0,0,1,0,3'd0,3'd0,0));
      ex_load(3'd1); ex_branch_taken = 1'b1;
      chk("lmff_flush", ev(0,1,1,0,0,3'd0,3'd0,0));
      idle_in();
      chk("lmff_aborted", ev(0,0,0,0,0,3'd0,3'd0,0));
      // Branch in IDLE overrides a load-use match
      rr_valid = 1'b1; rr_use_rs1 = 1'b1; rr_rs1 = 3'd2; ex_load(3'd2);
      ex_branch_taken = 1'b1;
      chk("idle_flush_over_hazard", ev(0,1,1,0,0,3'd0,3'd0,0));

      // Reset mid-sequence abandons it
      idle_in(); rr_lmsm(LM, 8'h0C);
      chk("lm0c_entry", ev(1,1,0,0,0,3'd0,3'd0,0));
      chk("lm0c_op0", ev(1,0,0,1,0,3'd2,3'd0,0));
      reset = 1'b1;
      chk("reset_mid_seq", ev(0,0,0,0,0,3'd0,3'd0,0));
      idle_in(); rr_lmsm(LM, 8'h00);
      chk("mask_zero", ev(0,0,0,0,0,3'd0,3'd0,0));
      idle_in();
      chk("no_seq_after_reset", ev(0,0,0,0,0,3'd0,3'd0,0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_seq_ctrl.md
Name: hazard_seq_ctrl

Overview:
- Pipeline sequencing controller for the 6-stage core (IF, ID, RR, EX, MR, WB).
- Sits beside the RR/EX forwarding logic and handles the hazards forwarding cannot cover:
  - load-use stalls;
  - taken-branch flushes;
  - multi-cycle LM/SM expansion.
- Drives the stage-register enables and flushes, and issues one register micro-op per cycle for LM/SM.

Parameters:
- OPC_LM, 4'b0110, opcode of load-multiple.
- OPC_SM, 4'b0111, opcode of store-multiple.
- PC_REG, 3'b111, register index aliased to the PC (never load-use checked).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rr_valid  in  1  RR stage holds a valid instruction
- rr_opcode  in  4  opcode of the RR instruction
- rr_rs1  in  3  source 1 (base register for LM/SM)
- rr_rs2  in  3  source 2
- rr_use_rs1  in  1  RR instruction reads rs1
- rr_use_rs2  in  1  RR instruction reads rs2
- rr_mask  in  8  LM/SM register mask; bit i selects Ri
- ex_valid  in  1  EX stage holds a valid instruction or micro-op
- ex_is_load  in  1  EX instruction is a load (LW or LM micro-op)
- ex_rd  in  3  EX destination register
- ex_branch_taken  in  1  EX resolved a redirect (branch, jump, or write to R7)
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_rr_stall  out  1  hold ID/RR register
- rr_ex_bubble  out  1  load a NOP into RR/EX
- flush_if_id  out  1  invalidate IF/ID
- flush_id_rr  out  1  invalidate ID/RR
- seq_valid  out  1  a LM/SM micro-op is presented to RR/EX this cycle
- seq_is_store  out  1  current micro-op is a store (SM)
- seq_reg  out  3  register index of the current micro-op
- seq_offset  out  3  word offset from the base; address = base + seq_offset
- seq_last  out  1  current micro-op is the final one

Behaviour:
- State machine states: IDLE, SEQ. Registered state:
  - rem_mask[7:0]
  - offset[2:0]
  - is_store
- Reset (checked first, every cycle it is high):
  - state = IDLE, rem_mask = 0, offset = 0, is_store = 0.
  - Every output is 0 while reset is high. Any in-progress LM/SM sequence is abandoned.
- Priority within a cycle: reset > ex_branch_taken > load-use hazard > LM/SM entry/progress.
- Flush (either state), when ex_branch_taken = 1:
  - flush_if_id = flush_id_rr = rr_ex_bubble = 1; all stalls = 0.
  - Next state is IDLE, rem_mask cleared. An in-progress sequence is aborted and seq_valid = 0 that cycle.
- Load-use hazard in IDLE, when all of the following hold:
  - rr_valid && ex_valid && ex_is_load;
  - ex_rd != PC_REG;
  - either (rr_use_rs1 && rr_rs1 == ex_rd) or (rr_use_rs2 && rr_rs2 == ex_rd).
- On a load-use hazard:
  - pc_stall = if_id_stall = id_rr_stall = rr_ex_bubble = 1 for that cycle only.
  - The condition clears naturally next cycle because EX then holds the bubble. No extra state.
- LM/SM entry: in IDLE, with rr_valid, opcode OPC_LM or OPC_SM, no flush and no hazard.
  - If rr_mask == 0: no stall, no bubble; the instruction passes down as a NOP.
  - Otherwise, at cycle T:
    - capture rem_mask = rr_mask, offset = 0, is_store = (opcode == OPC_SM);
    - assert all three stalls plus rr_ex_bubble;
    - next state = SEQ.
- SEQ, each cycle:
  - seq_reg = lowest set bit index of rem_mask.
  - seq_offset = offset; seq_is_store = is_store.
  - seq_last = exactly one bit remains set in rem_mask.
  - seq_valid = 1; rr_ex_bubble = 0.
  - On issue: clear that bit and increment offset.
- SEQ stalls:
  - pc_stall, if_id_stall and id_rr_stall stay high while !seq_last.
  - All three drop in the seq_last cycle, so the next instruction enters RR one cycle later.
  - SEQ -> IDLE after the seq_last cycle.
- SEQ store hazard, when all of the following hold:
  - is_store && ex_valid && ex_is_load;
  - ex_rd == seq_reg and seq_reg != PC_REG.
- On a SEQ store hazard:
  - seq_valid = 0, rr_ex_bubble = 1, all stalls high;
  - rem_mask and offset hold, so the same micro-op reissues next cycle.
- Latency: a mask with N bits set and no hazards gives:
  - the entry bubble at T;
  - micro-ops at T+1..T+N;
  - fetch resuming at T+N+1.
- Widths: offset is 3 bits and never wraps, because at most 8 micro-ops occur (mask 8'hFF gives offsets 0..7).

Test Plan:
- Load-use: EX = LW R3 (ex_is_load=1, ex_rd=3), RR reads rs1=3 -> exactly one cycle of pc/if_id/id_rr stall plus rr_ex_bubble; 0 on the next cycle when ex_valid=0.
- PC exemption and no-use: ex_rd=7 with rr_rs1=7, or rr_use_rs1=0 with a matching index -> no stall.
- LM with mask 8'b1010_0100 at T -> bubble at T; at T+1..T+3, seq_reg = 2, 5, 7 with offsets 0, 1, 2; seq_last at T+3; stalls low at T+3; state IDLE at T+4.
- SM with mask 8'h01, EX holding a load to R0 at T+1 -> seq_valid=0 plus bubble at T+1; micro-op R0, offset 0, issued at T+2 with seq_last=1.
- ex_branch_taken at T+2 of an LM with mask 8'hFF -> flushes plus bubble asserted, seq_valid=0, IDLE at T+3, no further micro-ops; a simultaneous load-use match is ignored.
- Reset asserted mid-SEQ -> all outputs 0 that cycle; IDLE with rem_mask=0 next; a mask of 0 issues no sequence.
